// File: rtl/fetch_reg.sv
// fetch_reg: IF/ID pipeline boundary. A small in-order queue that holds
// fetched instructions, their PCs and branch-predictor training metadata,
// and presents the oldest entry to decode on registered FF_* outputs.
// A decode stall never loses an instruction already returned by memory;
// a low fetch_control_i (mispredict redirect) empties the queue.

`ifndef nop_PC
`define nop_PC 32'h0000_0000
`endif
`ifndef nop_nPC
`define nop_nPC 32'h0000_0004
`endif
`ifndef nop_INSTR
`define nop_INSTR 32'h0000_0013
`endif
`ifndef nop_COMMIT
`define nop_COMMIT 1'b0
`endif

module fetch_reg #(
  parameter int DEPTH         = 2,
  parameter int PTR_W         = 1,
  parameter int PC_WIDTH      = 32,
  parameter int INSTR_WIDTH   = 32,
  parameter int history_WIDTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst,
  input  logic [PC_WIDTH-1:0]      F_PC_i,
  input  logic [PC_WIDTH-1:0]      F_nPC_i,
  input  logic [INSTR_WIDTH-1:0]   F_instr_i,
  input  logic                     F_commit_i,
  input  logic                     F_train_predict_i,
  input  logic [history_WIDTH-1:0] F_train_global_history_i,
  input  logic                     F_train_global_predict_i,
  input  logic                     F_train_local_predict_i,
  input  logic                     F_success_hit_i,
  input  logic [PC_WIDTH-1:0]      F_jmp_i,
  input  logic                     fetch_vaild_i,
  input  logic                     fetch_control_i,
  input  logic                     decode_allow_in_i,
  output logic                     fetch_allow_in_o,
  output logic                     fetch_vaild_o,
  output logic [PC_WIDTH-1:0]      FF_PC_o,
  output logic [PC_WIDTH-1:0]      FF_nPC_o,
  output logic [INSTR_WIDTH-1:0]   FF_instr_o,
  output logic                     FF_commit_o,
  output logic                     FF_train_predict_o,
  output logic [history_WIDTH-1:0] FF_train_global_history_o,
  output logic                     FF_train_global_predict_o,
  output logic                     FF_train_local_predict_o,
  output logic                     FF_success_hit_o,
  output logic [PC_WIDTH-1:0]      FF_jmp_o,
  output logic [PTR_W:0]           fetch_count_o
);

  localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0] ONE_CNT   = (PTR_W+1)'(1);

  localparam logic [PC_WIDTH-1:0]    NOP_PC     = PC_WIDTH'(`nop_PC);
  localparam logic [PC_WIDTH-1:0]    NOP_NPC    = PC_WIDTH'(`nop_nPC);
  localparam logic [INSTR_WIDTH-1:0] NOP_INSTR  = INSTR_WIDTH'(`nop_INSTR);
  localparam logic                   NOP_COMMIT = `nop_COMMIT;

  // Queue storage, one array per field. Contents are don't-care after reset.
  logic [PC_WIDTH-1:0]      pc_mem      [DEPTH];
  logic [PC_WIDTH-1:0]      npc_mem     [DEPTH];
  logic [INSTR_WIDTH-1:0]   instr_mem   [DEPTH];
  logic                     commit_mem  [DEPTH];
  logic                     predict_mem [DEPTH];
  logic [history_WIDTH-1:0] ghist_mem   [DEPTH];
  logic                     gpred_mem   [DEPTH];
  logic                     lpred_mem   [DEPTH];
  logic                     hit_mem     [DEPTH];
  logic [PC_WIDTH-1:0]      jmp_mem     [DEPTH];

  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr_nxt;
  logic [PTR_W:0]   count;

  logic flush;
  logic push;
  logic pop;
  logic bypass;
  logic advance;
  logic drain;

  logic [PC_WIDTH-1:0]      pc_nxt;
  logic [PC_WIDTH-1:0]      npc_nxt;
  logic [INSTR_WIDTH-1:0]   instr_nxt;
  logic                     commit_nxt;
  logic                     predict_nxt;
  logic [history_WIDTH-1:0] ghist_nxt;
  logic                     gpred_nxt;
  logic                     lpred_nxt;
  logic                     hit_nxt;
  logic [PC_WIDTH-1:0]      jmp_nxt;
  logic                     valid_nxt;

  // The head of the queue always lives in the FF_* registers, so the entry
  // that follows it sits one slot past rd_ptr.
  assign rd_ptr_nxt = rd_ptr + PTR_W'(1);

  // Handshakes. Accepting on a full queue is fine when decode drains the
  // head in the same cycle, which keeps a streaming pipe bubble-free.
  assign flush            = ~fetch_control_i;
  assign fetch_allow_in_o = (count != DEPTH_CNT) | decode_allow_in_i;
  assign push             = fetch_vaild_i & fetch_allow_in_o & fetch_control_i;
  assign pop              = fetch_vaild_o & decode_allow_in_i & fetch_control_i;
  assign fetch_count_o    = count;

  // Classify how the head registers change this cycle: take the incoming
  // entry straight through, step to the next stored entry, or go idle.
  assign bypass  = push & ((count == '0) | ((count == ONE_CNT) & pop));
  assign advance = pop & (count > ONE_CNT);
  assign drain   = pop & (count == ONE_CNT) & ~push;

  // Every accepted entry is written to storage, including bypassed ones, so
  // that mem[rd_ptr] always mirrors the current head.
  always_ff @(posedge clk_i) begin
    if (push) begin
      pc_mem[wr_ptr]      <= F_PC_i;
      npc_mem[wr_ptr]     <= F_nPC_i;
      instr_mem[wr_ptr]   <= F_instr_i;
      commit_mem[wr_ptr]  <= F_commit_i;
      predict_mem[wr_ptr] <= F_train_predict_i;
      ghist_mem[wr_ptr]   <= F_train_global_history_i;
      gpred_mem[wr_ptr]   <= F_train_global_predict_i;
      lpred_mem[wr_ptr]   <= F_train_local_predict_i;
      hit_mem[wr_ptr]     <= F_success_hit_i;
      jmp_mem[wr_ptr]     <= F_jmp_i;
    end
  end

  // Pointer and occupancy bookkeeping; flush wipes everything back to empty.
  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr_nxt;
      end
      case ({push, pop})
        2'b10:   count <= count + ONE_CNT;
        2'b01:   count <= count - ONE_CNT;
        default: count <= count;
      endcase
    end
  end

  // Next-state selection for the head registers: hold by default, nop on
  // flush or when the last entry leaves, otherwise the incoming or next entry.
  always_comb begin
    pc_nxt      = FF_PC_o;
    npc_nxt     = FF_nPC_o;
    instr_nxt   = FF_instr_o;
    commit_nxt  = FF_commit_o;
    predict_nxt = FF_train_predict_o;
    ghist_nxt   = FF_train_global_history_o;
    gpred_nxt   = FF_train_global_predict_o;
    lpred_nxt   = FF_train_local_predict_o;
    hit_nxt     = FF_success_hit_o;
    jmp_nxt     = FF_jmp_o;
    valid_nxt   = fetch_vaild_o;
    if (flush | drain) begin
      pc_nxt      = NOP_PC;
      npc_nxt     = NOP_NPC;
      instr_nxt   = NOP_INSTR;
      commit_nxt  = NOP_COMMIT;
      predict_nxt = 1'b0;
      ghist_nxt   = '0;
      gpred_nxt   = 1'b0;
      lpred_nxt   = 1'b0;
      hit_nxt     = 1'b0;
      jmp_nxt     = '0;
      valid_nxt   = 1'b0;
    end else if (bypass) begin
      pc_nxt      = F_PC_i;
      npc_nxt     = F_nPC_i;
      instr_nxt   = F_instr_i;
      commit_nxt  = F_commit_i;
      predict_nxt = F_train_predict_i;
      ghist_nxt   = F_train_global_history_i;
      gpred_nxt   = F_train_global_predict_i;
      lpred_nxt   = F_train_local_predict_i;
      hit_nxt     = F_success_hit_i;
      jmp_nxt     = F_jmp_i;
      valid_nxt   = 1'b1;
    end else if (advance) begin
      pc_nxt      = pc_mem[rd_ptr_nxt];
      npc_nxt     = npc_mem[rd_ptr_nxt];
      instr_nxt   = instr_mem[rd_ptr_nxt];
      commit_nxt  = commit_mem[rd_ptr_nxt];
      predict_nxt = predict_mem[rd_ptr_nxt];
      ghist_nxt   = ghist_mem[rd_ptr_nxt];
      gpred_nxt   = gpred_mem[rd_ptr_nxt];
      lpred_nxt   = lpred_mem[rd_ptr_nxt];
      hit_nxt     = hit_mem[rd_ptr_nxt];
      jmp_nxt     = jmp_mem[rd_ptr_nxt];
      valid_nxt   = 1'b1;
    end
  end

  // Registered decode-side outputs; reset presents a bubble immediately.
  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      FF_PC_o                   <= NOP_PC;
      FF_nPC_o                  <= NOP_NPC;
      FF_instr_o                <= NOP_INSTR;
      FF_commit_o               <= NOP_COMMIT;
      FF_train_predict_o        <= 1'b0;
      FF_train_global_history_o <= '0;
      FF_train_global_predict_o <= 1'b0;
      FF_train_local_predict_o  <= 1'b0;
      FF_success_hit_o          <= 1'b0;
      FF_jmp_o                  <= '0;
      fetch_vaild_o             <= 1'b0;
    end else begin
      FF_PC_o                   <= pc_nxt;
      FF_nPC_o                  <= npc_nxt;
      FF_instr_o                <= instr_nxt;
      FF_commit_o               <= commit_nxt;
      FF_train_predict_o        <= predict_nxt;
      FF_train_global_history_o <= ghist_nxt;
      FF_train_global_predict_o <= gpred_nxt;
      FF_train_local_predict_o  <= lpred_nxt;
      FF_success_hit_o          <= hit_nxt;
      FF_jmp_o                  <= jmp_nxt;
      fetch_vaild_o             <= valid_nxt;
    end
  end

endmodule

// File: tb/tb_fetch_reg.sv
// tb_fetch_reg: scoreboard bench for fetch_reg. The driver pushes every
// accepted entry into an expected queue; a negedge monitor compares the
// DUT's head, occupancy and ready against that queue and retires entries
// as decode consumes them.

module tb_fetch_reg;

  localparam int DEPTH   = 2;
  localparam int PTR_W   = 1;
  localparam int PC_W    = 32;
  localparam int INSTR_W = 32;
  localparam int HIST_W  = 8;

  localparam logic [PC_W-1:0]    NOP_PC     = 32'h0000_0000;
  localparam logic [PC_W-1:0]    NOP_NPC    = 32'h0000_0004;
  localparam logic [INSTR_W-1:0] NOP_INSTR  = 32'h0000_0013;
  localparam logic               NOP_COMMIT = 1'b0;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [PC_W-1:0]    npc;
    logic [INSTR_W-1:0] instr;
    logic               commit;
    logic               predict;
    logic [HIST_W-1:0]  ghist;
    logic               gpred;
    logic               lpred;
    logic               hit;
    logic [PC_W-1:0]    jmp;
  } entry_t;

  logic clk_i = 1'b0;
  logic rst;
  entry_t f_in;
  logic fetch_vaild_i;
  logic fetch_control_i;
  logic decode_allow_in_i;
  logic fetch_allow_in_o;
  logic fetch_vaild_o;
  logic [PC_W-1:0]    FF_PC_o;
  logic [PC_W-1:0]    FF_nPC_o;
  logic [INSTR_W-1:0] FF_instr_o;
  logic               FF_commit_o;
  logic               FF_train_predict_o;
  logic [HIST_W-1:0]  FF_train_global_history_o;
  logic               FF_train_global_predict_o;
  logic               FF_train_local_predict_o;
  logic               FF_success_hit_o;
  logic [PC_W-1:0]    FF_jmp_o;
  logic [PTR_W:0]     fetch_count_o;
  entry_t head;

  entry_t exp_q[$];
  int n_checks = 0;
  int n_fail = 0;
  bit mon_en = 1'b0;

  fetch_reg #(
    .DEPTH(DEPTH), .PTR_W(PTR_W), .PC_WIDTH(PC_W),
    .INSTR_WIDTH(INSTR_W), .history_WIDTH(HIST_W)
  ) dut (
    .clk_i(clk_i),
    .rst(rst),
    .F_PC_i(f_in.pc),
    .F_nPC_i(f_in.npc),
    .F_instr_i(f_in.instr),
    .F_commit_i(f_in.commit),
    .F_train_predict_i(f_in.predict),
    .F_train_global_history_i(f_in.ghist),
    .F_train_global_predict_i(f_in.gpred),
    .F_train_local_predict_i(f_in.lpred),
    .F_success_hit_i(f_in.hit),
    .F_jmp_i(f_in.jmp),
    .fetch_vaild_i(fetch_vaild_i),
    .fetch_control_i(fetch_control_i),
    .decode_allow_in_i(decode_allow_in_i),
    .fetch_allow_in_o(fetch_allow_in_o),
    .fetch_vaild_o(fetch_vaild_o),
    .FF_PC_o(FF_PC_o),
    .FF_nPC_o(FF_nPC_o),
    .FF_instr_o(FF_instr_o),
    .FF_commit_o(FF_commit_o),
    .FF_train_predict_o(FF_train_predict_o),
    .FF_train_global_history_o(FF_train_global_history_o),
    .FF_train_global_predict_o(FF_train_global_predict_o),
    .FF_train_local_predict_o(FF_train_local_predict_o),
    .FF_success_hit_o(FF_success_hit_o),
    .FF_jmp_o(FF_jmp_o),
    .fetch_count_o(fetch_count_o)
  );

  assign head = {FF_PC_o, FF_nPC_o, FF_instr_o, FF_commit_o, FF_train_predict_o,
                 FF_train_global_history_o, FF_train_global_predict_o,
                 FF_train_local_predict_o, FF_success_hit_o, FF_jmp_o};

  // Free-running clock.
  always #5 clk_i = ~clk_i;

  // Hard stop if the run ever stalls.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic entry_t nopEntry();
    entry_t e;
    e = '0;
    e.pc = NOP_PC;
    e.npc = NOP_NPC;
    e.instr = NOP_INSTR;
    e.commit = NOP_COMMIT;
    return e;
  endfunction

  function automatic entry_t makeEntry(input logic [PC_W-1:0] pc);
    entry_t e;
    e.pc = pc;
    e.npc = pc + 32'd4;
    e.instr = $urandom;
    e.commit = 1'($urandom);
    e.predict = 1'($urandom);
    e.ghist = 8'($urandom);
    e.gpred = 1'($urandom);
    e.lpred = 1'($urandom);
    e.hit = 1'($urandom);
    e.jmp = $urandom;
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drives one cycle of stimulus (called one step after a rising edge) and
  // records the entry in the expected queue if the queue model accepts it.
  task automatic applyStimulus(input entry_t e, input logic v, input logic da, input logic ctl);
    bit took;
    f_in = e;
    fetch_vaild_i = v;
    decode_allow_in_i = da;
    fetch_control_i = ctl;
    took = v && ctl && ((exp_q.size() < DEPTH) || da);
    @(posedge clk_i);
    if (!ctl) exp_q.delete();
    else if (took) exp_q.push_back(e);
    #1;
  endtask

  // Monitor: compare the DUT against the expected queue every cycle and
  // retire the head entry when decode takes it.
  always @(negedge clk_i) begin
    if (mon_en && !rst) begin
      checkOutput("count", 160'(fetch_count_o), 160'(exp_q.size()));
      checkOutput("allow_in", 160'(fetch_allow_in_o),
                  160'((exp_q.size() < DEPTH) || decode_allow_in_i));
      if (exp_q.size() == 0) begin
        checkOutput("valid_empty", 160'(fetch_vaild_o), 160'(1'b0));
        checkOutput("head_nop", 160'(head), 160'(nopEntry()));
      end else begin
        checkOutput("valid_busy", 160'(fetch_vaild_o), 160'(1'b1));
        checkOutput("head_entry", 160'(head), 160'(exp_q[0]));
        if (decode_allow_in_i && fetch_control_i) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    rst = 1'b1;
    f_in = '0;
    fetch_vaild_i = 1'b0;
    decode_allow_in_i = 1'b0;
    fetch_control_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    checkOutput("rst_pc", 160'(FF_PC_o), 160'(NOP_PC));
    checkOutput("rst_instr", 160'(FF_instr_o), 160'(NOP_INSTR));
    checkOutput("rst_valid", 160'(fetch_vaild_o), 160'(1'b0));
    checkOutput("rst_count", 160'(fetch_count_o), 160'(0));
    checkOutput("rst_allow", 160'(fetch_allow_in_o), 160'(1'b1));
    rst = 1'b0;
    mon_en = 1'b1;
    applyStimulus('0, 1'b0, 1'b1, 1'b1);

    $display("[TB] streaming");
    applyStimulus(makeEntry(32'h1000), 1'b1, 1'b1, 1'b1);
    applyStimulus(makeEntry(32'h1004), 1'b1, 1'b1, 1'b1);
    applyStimulus(makeEntry(32'h1008), 1'b1, 1'b1, 1'b1);
    checkOutput("stream_pc", 160'(FF_PC_o), 160'(32'h1008));
    applyStimulus('0, 1'b0, 1'b1, 1'b1);
    applyStimulus('0, 1'b0, 1'b1, 1'b1);

    $display("[TB] stall fill and release");
    applyStimulus(makeEntry(32'h2000), 1'b1, 1'b0, 1'b1);
    applyStimulus(makeEntry(32'h2004), 1'b1, 1'b0, 1'b1);
    applyStimulus(makeEntry(32'h2008), 1'b1, 1'b0, 1'b1);
    checkOutput("stall_pc", 160'(FF_PC_o), 160'(32'h2000));
    checkOutput("stall_full", 160'(fetch_allow_in_o), 160'(1'b0));
    repeat (3) applyStimulus('0, 1'b0, 1'b1, 1'b1);

    $display("[TB] full with simultaneous pop");
    applyStimulus(makeEntry(32'h2100), 1'b1, 1'b0, 1'b1);
    applyStimulus(makeEntry(32'h2104), 1'b1, 1'b0, 1'b1);
    applyStimulus(makeEntry(32'h3000), 1'b1, 1'b1, 1'b1);
    checkOutput("full_pop_count", 160'(fetch_count_o), 160'(2));
    checkOutput("full_pop_pc", 160'(FF_PC_o), 160'(32'h2104));
    repeat (3) applyStimulus('0, 1'b0, 1'b1, 1'b1);

    $display("[TB] flush");
    applyStimulus(makeEntry(32'h3100), 1'b1, 1'b0, 1'b1);
    applyStimulus(makeEntry(32'h3104), 1'b1, 1'b0, 1'b1);
    applyStimulus(makeEntry(32'h5000), 1'b1, 1'b1, 1'b0);
    checkOutput("flush_count", 160'(fetch_count_o), 160'(0));
    checkOutput("flush_valid", 160'(fetch_vaild_o), 160'(1'b0));
    applyStimulus(makeEntry(32'h4000), 1'b1, 1'b0, 1'b1);
    checkOutput("post_flush_pc", 160'(FF_PC_o), 160'(32'h4000));
    applyStimulus('0, 1'b0, 1'b1, 1'b1);

    $display("[TB] async reset mid-cycle");
    applyStimulus(makeEntry(32'h6000), 1'b1, 1'b0, 1'b1);
    applyStimulus(makeEntry(32'h6004), 1'b1, 1'b0, 1'b1);
    checkOutput("pre_reset_count", 160'(fetch_count_o), 160'(2));
    f_in = '0;
    fetch_vaild_i = 1'b0;
    decode_allow_in_i = 1'b0;
    fetch_control_i = 1'b1;
    #2 rst = 1'b1;
    #1;
    checkOutput("arst_pc", 160'(FF_PC_o), 160'(NOP_PC));
    checkOutput("arst_instr", 160'(FF_instr_o), 160'(NOP_INSTR));
    checkOutput("arst_valid", 160'(fetch_vaild_o), 160'(1'b0));
    checkOutput("arst_count", 160'(fetch_count_o), 160'(0));
    exp_q.delete();
    rst = 1'b0;
    @(posedge clk_i);
    #1;

    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++) begin
      applyStimulus(makeEntry($urandom),
                    1'($urandom_range(0, 3) != 0),
                    1'($urandom_range(0, 2) != 0),
                    1'($urandom_range(0, 19) != 0));
    end
    repeat (4) applyStimulus('0, 1'b0, 1'b1, 1'b1);

    mon_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
